// File: rtl/jesd204b_pkg.sv
// Shared constants for the JESD204B scrambler family: polynomial taps,
// default seed and octet width.
package jesd204b_pkg;

    localparam int TAP_A   = 14;
    localparam int TAP_B   = 15;
    localparam int STATE_W = 15;
    localparam int OCTET_W = 8;

    localparam logic [STATE_W-1:0] DEFAULT_SEED = 15'h7F80;

    typedef enum logic {
        MODE_SCRAMBLE   = 1'b0,
        MODE_DESCRAMBLE = 1'b1
    } scr_mode_e;

endpackage

// File: rtl/jesd204b_scr_lane.sv
// One lane of the 1+x^14+x^15 self-synchronous scrambler, W bits per clock.
// Descramble datapath present only when JESD_SCR_DESCRAMBLE_EN is defined.
module jesd204b_scr_lane
    import jesd204b_pkg::*;
#(
    parameter int                 W    = 32,
    parameter logic [STATE_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_seed,
    input  logic         in_valid,
    input  logic         scr_en,
    input  logic         mode,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [STATE_W-1:0]   state_reg;
    logic [STATE_W-1:0]   state_next;
    logic [STATE_W-1:0]   state_eff;
    logic [STATE_W-1:0]   proc_state;
    logic [W-1:0]         scr_data;
    logic [W-1:0]         proc_data;
    logic [STATE_W+W-1:0] ext_scr;

    // A reload in the same beat makes that beat start from SEED.
    assign state_eff = load_seed ? SEED : state_reg;

    // Time-ordered bit history: [STATE_W-1:0] is the stored state (oldest at 0),
    // entry STATE_W+i is the scrambled bit of the i-th bit in time (din[W-1-i]).
    // Each new bit feeds later ones, so this chain lives in one process.
    always_comb begin
        ext_scr = '0;
        ext_scr[STATE_W-1:0] = state_eff;
        for (int i = 0; i < W; i++) begin
            ext_scr[STATE_W+i] = din[W-1-i] ^ ext_scr[STATE_W+i-TAP_A]
                                            ^ ext_scr[STATE_W+i-TAP_B];
        end
    end

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_scr_bit
            assign scr_data[W-1-gi] = ext_scr[STATE_W+gi];
        end
    endgenerate

`ifdef JESD_SCR_DESCRAMBLE_EN
    logic [STATE_W+W-1:0] ext_rx;
    logic [W-1:0]         desc_data;

    assign ext_rx[STATE_W-1:0] = state_eff;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_desc_bit
            assign ext_rx[STATE_W+gi] = din[W-1-gi];
            assign desc_data[W-1-gi]  = din[W-1-gi] ^ ext_rx[STATE_W+gi-TAP_A]
                                                    ^ ext_rx[STATE_W+gi-TAP_B];
        end
    endgenerate

    assign proc_data  = (mode == MODE_DESCRAMBLE) ? desc_data : scr_data;
    assign proc_state = (mode == MODE_DESCRAMBLE) ? ext_rx[W +: STATE_W]
                                                  : ext_scr[W +: STATE_W];
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign proc_data   = scr_data;
    assign proc_state  = ext_scr[W +: STATE_W];
`endif

    assign dout = scr_en ? proc_data : din;

    // Bypass beats leave the state alone, apart from any requested reload.
    always_comb begin
        state_next = state_reg;
        if (in_valid && scr_en) begin
            state_next = proc_state;
        end else if (load_seed) begin
            state_next = SEED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SEED;
        end else begin
            state_reg <= state_next;
        end
    end

endmodule

// File: rtl/jesd204b_scrambler_mlane.sv
// Multi-lane JESD204B scrambler/descrambler, one cycle latency.
// Define JESD_SCR_DESCRAMBLE_EN to enable the descramble datapath (mode=1).
module jesd204b_scrambler_mlane
    import jesd204b_pkg::*;
#(
    parameter int                 LANES  = 4,
    parameter int                 OCTETS = 4,
    parameter logic [STATE_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sync_rst,
    input  logic                          scr_en,
    input  logic                          mode,
    input  logic                          in_valid,
    input  logic [LANES*OCTETS*OCTET_W-1:0] in_data,
    output logic                          out_valid,
    output logic [LANES*OCTETS*OCTET_W-1:0] out_data
);

    localparam int W  = OCTETS * OCTET_W;
    localparam int DW = LANES * W;

    logic [DW-1:0] lane_dout;
    logic [DW-1:0] out_data_reg;
    logic [DW-1:0] out_data_next;
    logic          out_valid_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            jesd204b_scr_lane #(
                .W    (W),
                .SEED (SEED)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .load_seed (sync_rst),
                .in_valid  (in_valid),
                .scr_en    (scr_en),
                .mode      (mode),
                .din       (in_data[gi*W +: W]),
                .dout      (lane_dout[gi*W +: W])
            );
        end
    endgenerate

    // Output word only moves on valid beats so it holds across gaps.
    assign out_data_next = in_valid ? lane_dout : out_data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= in_valid;
            out_data_reg  <= out_data_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule
